// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-to-UART drain block.
package fifo_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      CHECK,
      START,
      DATA,
      PARITY,
      STOP,
      BACKOFF
   } state_t;

   localparam int   DATA_BITS       = 8;
   localparam int   FRAME_BITS_BASE = 10;
   localparam logic TX_IDLE         = 1'b1;

endpackage

// File: rtl/fifo_uart_drain_baud_tick_gen.sv
// Bit-period timer: down-counter with synchronous clear, ticks on the last
// cycle of each BAUD_DIV-cycle period.
module baud_tick_gen #(
   parameter int BAUD_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int           W    = $clog2(BAUD_DIV) + 1;
   localparam logic [W-1:0] LOAD = W'(BAUD_DIV - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr || cnt == '0)
         cnt <= LOAD;
      else
         cnt <= cnt - W'(1);
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/fifo_uart_drain.sv
// Drains the 8-deep byte FIFO onto a UART-style serial line, probing by read.
// Optional even-parity bit: define FIFO_UART_PARITY_EN.
module fifo_uart_drain
   import fifo_uart_pkg::*;
#(
   parameter int BAUD_DIV  = 4,
   parameter int RETRY_GAP = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic       fifo_ren,
   input  logic [7:0] fifo_dout,
   input  logic       fifo_error,
   output logic       tx,
   output logic       busy,
   output logic [7:0] byte_cnt
);

   localparam int GW = $clog2(RETRY_GAP) + 1;

   state_t        state, state_n;
   logic [7:0]    shreg, shreg_n;
   logic [2:0]    bitcnt, bitcnt_n;
   logic [GW-1:0] gap, gap_n;
   logic          cnt_inc;
   logic          tx_n;
   logic          tick;
   logic          baud_clr;
`ifdef FIFO_UART_PARITY_EN
   logic          par, par_n;
`endif

   // Restarting the bit timer on every state change aligns each bit period
   // with the first cycle of its state.
   assign baud_clr = (state_n != state);

   baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (baud_clr),
      .tick  (tick)
   );

   always_comb begin
      state_n  = state;
      shreg_n  = shreg;
      bitcnt_n = bitcnt;
      gap_n    = gap;
      cnt_inc  = 1'b0;
`ifdef FIFO_UART_PARITY_EN
      par_n    = par;
`endif
      case (state)
         IDLE:    if (en) state_n = REQ;
         REQ:     state_n = CHECK;
         CHECK: begin
            if (fifo_error) begin
               gap_n   = '0;
               state_n = BACKOFF;
            end else begin
               shreg_n = fifo_dout;
`ifdef FIFO_UART_PARITY_EN
               par_n   = ^fifo_dout;
`endif
               state_n = START;
            end
         end
         START: begin
            if (tick) begin
               bitcnt_n = '0;
               state_n  = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               shreg_n = shreg >> 1;
               if (bitcnt == 3'(DATA_BITS - 1))
`ifdef FIFO_UART_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               else
                  bitcnt_n = bitcnt + 3'd1;
            end
         end
`ifdef FIFO_UART_PARITY_EN
         PARITY:  if (tick) state_n = STOP;
`endif
         STOP: begin
            if (tick) begin
               cnt_inc = 1'b1;
               state_n = en ? REQ : IDLE;
            end
         end
         BACKOFF: begin
            if (gap == GW'(RETRY_GAP - 1))
               state_n = IDLE;
            else
               gap_n = gap + GW'(1);
         end
         default: state_n = IDLE;
      endcase
   end

   // tx is registered from the next-state view so the line changes together
   // with the state it belongs to.
   always_comb begin
      tx_n = TX_IDLE;
      case (state_n)
         START:  tx_n = 1'b0;
         DATA:   tx_n = shreg_n[0];
`ifdef FIFO_UART_PARITY_EN
         PARITY: tx_n = par_n;
`endif
         default: tx_n = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         shreg    <= '0;
         bitcnt   <= '0;
         gap      <= '0;
         byte_cnt <= '0;
         tx       <= TX_IDLE;
         fifo_ren <= 1'b0;
`ifdef FIFO_UART_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         shreg    <= shreg_n;
         bitcnt   <= bitcnt_n;
         gap      <= gap_n;
         byte_cnt <= byte_cnt + 8'(cnt_inc);
         tx       <= tx_n;
         fifo_ren <= (state_n == REQ);
`ifdef FIFO_UART_PARITY_EN
         par      <= par_n;
`endif
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed self-checking bench for fifo_uart_drain with a queue-backed FIFO model.
module tb_fifo_uart_drain;

   localparam int B = 4;
   localparam int G = 8;
`ifdef FIFO_UART_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int P = 2 + FB * B;

   logic       clk, rst_n, en;
   logic       fifo_ren, fifo_error, tx, busy;
   logic [7:0] fifo_dout, byte_cnt;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] fifo_q[$];

   fifo_uart_drain #(.BAUD_DIV(B), .RETRY_GAP(G)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .fifo_ren   (fifo_ren),
      .fifo_dout  (fifo_dout),
      .fifo_error (fifo_error),
      .tx         (tx),
      .busy       (busy),
      .byte_cnt   (byte_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // FIFO read port: data/error valid the cycle after a sampled ren.
   initial begin
      fifo_dout  = 8'h00;
      fifo_error = 1'b0;
      forever begin
         @(posedge clk);
         if (fifo_ren === 1'b1) begin
            #1;
            if (fifo_q.size() > 0) begin
               fifo_dout  = fifo_q.pop_front();
               fifo_error = 1'b0;
            end else begin
               fifo_dout  = 8'hA5;
               fifo_error = 1'b1;
            end
         end
      end
   end

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s (k=%0d): observed %0h expected %0h", tag, k, obs, exp);
      end
   endtask

   function automatic logic exp_tx(input logic [7:0] b, input int k);
      int j;
      if (k < 2) return 1'b1;
      j = k - 2;
      if (j < B) return 1'b0;
      j -= B;
      if (j < 8 * B) return b[j / B];
      j -= 8 * B;
`ifdef FIFO_UART_PARITY_EN
      if (j < B) return ^b;
`endif
      return 1'b1;
   endfunction

   // Called at the negedge of a REQ cycle whose probe returns error.
   task automatic probe_empty(input logic [7:0] cnt);
      for (int k = 1; k <= 2 + G + 1; k++) begin
         @(negedge clk);
         if (k < 2 + G + 1) begin
            chk("empty_tx", k, tx, 1'b1);
            chk("empty_ren", k, fifo_ren, 1'b0);
         end
         if (k == 5)  chk("backoff_busy", k, busy, 1'b1);
         if (k == 10) chk("idle_busy", k, busy, 1'b0);
         if (k == 2 + G + 1) begin
            chk("reprobe_ren", k, fifo_ren, 1'b1);
            chk("empty_cnt", k, byte_cnt, cnt);
         end
      end
   endtask

   // Called at the negedge of the REQ cycle that fetches byte b.
   task automatic frame(input logic [7:0] b, input bit drop, input logic [7:0] cnt);
      for (int k = 1; k <= P; k++) begin
         @(negedge clk);
         if (k < P) begin
            chk("frame_tx", k, tx, exp_tx(b, k));
            chk("frame_ren", k, fifo_ren, 1'b0);
            chk("frame_busy", k, busy, 1'b1);
            chk("frame_cnt", k, byte_cnt, cnt - 8'd1);
         end else begin
            chk("next_ren", k, fifo_ren, !drop);
            chk("done_cnt", k, byte_cnt, cnt);
            chk("done_tx", k, tx, 1'b1);
            chk("done_busy", k, busy, !drop);
         end
         if (drop && k == 10) en = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_tx", i, tx, 1'b1);
         chk("rst_ren", i, fifo_ren, 1'b0);
         chk("rst_busy", i, busy, 1'b0);
         chk("rst_cnt", i, byte_cnt, 8'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_ren", 0, fifo_ren, 1'b1);
      chk("first_busy", 0, busy, 1'b1);

      probe_empty(8'd0);
      probe_empty(8'd0);

      // Loaded while the probe is in flight, so this REQ fetches 0x38.
      fifo_q.push_back(8'd56);
      fifo_q.push_back(8'd11);
      fifo_q.push_back(8'd42);
      fifo_q.push_back(8'd10);
      frame(8'd56, 1'b0, 8'd1);
      frame(8'd11, 1'b0, 8'd2);
      frame(8'd42, 1'b0, 8'd3);
      frame(8'd10, 1'b0, 8'd4);
      probe_empty(8'd4);

      fifo_q.push_back(8'd11);
      frame(8'd11, 1'b1, 8'd5);
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         chk("post_drop_ren", k, fifo_ren, 1'b0);
         chk("post_drop_tx", k, tx, 1'b1);
      end
      chk("post_drop_cnt", 0, byte_cnt, 8'd5);
      chk("post_drop_busy", 0, busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
